// File: rtl/core_run_controller.sv
// core_run_controller: run/halt/step/reset sequencer for a core with rvfi retirement tracking.
// Define TRACE_EN to build the first-word-fall-through retirement trace FIFO.
module core_run_controller #(
   parameter int XLEN           = 32,
   parameter int TRACE_DEPTH    = 16,
   parameter int RESET_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [31:0]                  cmd_arg,
   output logic                         core_clk_en,
   output logic                         reset_core,
   input  logic                         rvfi_valid,
   input  logic                         rvfi_trap,
   input  logic [XLEN-1:0]              rvfi_pc_rdata,
   input  logic [31:0]                  rvfi_insn,
   input  logic                         bkpt_en,
   input  logic [XLEN-1:0]              bkpt_addr,
   input  logic                         trace_rd_en,
   output logic [XLEN+31:0]             trace_data,
   output logic                         trace_empty,
   output logic [$clog2(TRACE_DEPTH):0] trace_count,
   output logic                         trace_overflow,
   output logic [1:0]                   state,
   output logic [1:0]                   halt_reason,
   output logic [63:0]                  retired
);
   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_RST = 2'd3} state_t;
   state_t st, st_nx;
   logic [1:0] why, why_nx;
   logic [31:0] rem, rem_nx;
   logic [RW-1:0] rcnt, rcnt_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic accept, retire, flush;
   assign cmd_ready   = st != S_RST;
   assign core_clk_en = st == S_RUN || st == S_STEP;
   assign reset_core  = st == S_RST;
   assign state       = st;
   assign halt_reason = why;
   assign accept      = cmd_valid && cmd_ready;
   assign retire      = rvfi_valid && core_clk_en;
   assign flush       = accept && cmd_op == 2'd3;
   // An accepted command overrides any halt event raised in the same cycle.
   always_comb begin
      st_nx = st;
      why_nx = why;
      rem_nx = rem;
      rcnt_nx = rcnt;
      tcnt_nx = tcnt;
      if (accept) begin
         st_nx = cmd_op == 2'd0 ? S_RUN : cmd_op == 2'd1 ? S_HALT : cmd_op == 2'd2 ? S_STEP : S_RST;
         why_nx = cmd_op == 2'd1 ? 2'd0 : why;
         rem_nx = cmd_arg == 32'd0 ? 32'd1 : cmd_arg;
         rcnt_nx = '0;
         tcnt_nx = '0;
      end else if (st == S_RST) begin
         rcnt_nx = rcnt + 1'b1;
         if (rcnt == RW'(RESET_CYCLES - 1)) begin st_nx = S_HALT; why_nx = 2'd0; end
      end else begin
         if (st == S_STEP) begin
            rem_nx = retire ? rem - 1'b1 : rem;
            tcnt_nx = retire ? '0 : tcnt + 1'b1;
         end
         if (retire && rvfi_trap) begin st_nx = S_HALT; why_nx = 2'd2; end
         else if (retire && bkpt_en && rvfi_pc_rdata == bkpt_addr) begin st_nx = S_HALT; why_nx = 2'd1; end
         else if (retire && st == S_STEP && rem == 32'd1) begin st_nx = S_HALT; why_nx = 2'd0; end
         else if (st == S_STEP && !retire && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin st_nx = S_HALT; why_nx = 2'd3; end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st <= S_RST;
         why <= 2'd0;
         rem <= '0;
         rcnt <= '0;
         tcnt <= '0;
         retired <= '0;
      end else begin
         st <= st_nx;
         why <= why_nx;
         rem <= rem_nx;
         rcnt <= rcnt_nx;
         tcnt <= tcnt_nx;
         retired <= flush ? 64'd0 : retired + 64'(retire);
      end
   end
`ifdef TRACE_EN
   localparam int AW = $clog2(TRACE_DEPTH);
   localparam int CW = AW + 1;
   logic [XLEN+31:0] mem [TRACE_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic ovf, pop, wr;
   // A pop frees the head slot, so a push into a full FIFO still lands when paired with one.
   assign pop = trace_rd_en && cnt != '0;
   assign wr  = retire && (cnt != CW'(TRACE_DEPTH) || pop);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         wp <= wr ? wp + 1'b1 : wp;
         rp <= pop ? rp + 1'b1 : rp;
         cnt <= cnt + CW'(wr) - CW'(pop);
         ovf <= ovf | (retire && !wr);
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= {rvfi_pc_rdata, rvfi_insn};
   end
   assign trace_data     = cnt == '0 ? '0 : mem[rp];
   assign trace_empty    = cnt == '0;
   assign trace_count    = cnt;
   assign trace_overflow = ovf;
`else
   logic unused_trace;
   assign unused_trace   = ^{trace_rd_en, rvfi_insn, flush};
   assign trace_data     = '0;
   assign trace_empty    = 1'b1;
   assign trace_count    = '0;
   assign trace_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller: vector table, directed corner sequences and random traffic vs a queue-based model.
module tb_core_run_controller;
   localparam int XLEN = 32, DEPTH = 16, RC = 8, TMO = 1024;
`ifdef TRACE_EN
   localparam bit TRACE = 1'b1;
`else
   localparam bit TRACE = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [1:0] cmd_op = '0;
   logic [31:0] cmd_arg = '0;
   logic core_clk_en, reset_core;
   logic rvfi_valid = 1'b0, rvfi_trap = 1'b0;
   logic [XLEN-1:0] rvfi_pc_rdata = '0, bkpt_addr = '0;
   logic [31:0] rvfi_insn = '0;
   logic bkpt_en = 1'b0, trace_rd_en = 1'b0;
   logic [XLEN+31:0] trace_data;
   logic trace_empty, trace_overflow;
   logic [$clog2(DEPTH):0] trace_count;
   logic [1:0] state, halt_reason;
   logic [63:0] retired;
   core_run_controller #(.XLEN(XLEN), .TRACE_DEPTH(DEPTH), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_arg(cmd_arg), .core_clk_en(core_clk_en), .reset_core(reset_core), .rvfi_valid(rvfi_valid),
      .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn), .bkpt_en(bkpt_en),
      .bkpt_addr(bkpt_addr), .trace_rd_en(trace_rd_en), .trace_data(trace_data), .trace_empty(trace_empty),
      .trace_count(trace_count), .trace_overflow(trace_overflow), .state(state), .halt_reason(halt_reason),
      .retired(retired)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   // Reference model: state as plain ints, trace as a queue.
   int m_st, m_why, m_rstc, m_idle;
   longint m_rem;
   logic [63:0] m_ret;
   logic [XLEN+31:0] m_q[$];
   bit m_ovf;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic void m_reset();
      m_st = 3; m_why = 0; m_rstc = 0; m_idle = 0; m_rem = 0; m_ret = 0; m_ovf = 0;
      m_q.delete();
   endfunction
   function automatic void mstep();
      bit act, r, acc, pop, full, done, tout;
      int nst;
      act = m_st == 1 || m_st == 2;
      r = rvfi_valid && act;
      acc = cmd_valid && m_st != 3;
      nst = m_st;
      pop = trace_rd_en && m_q.size() != 0;
      full = m_q.size() == DEPTH;
      if (r) m_ret++;
      if (pop) void'(m_q.pop_front());
      if (r) begin
         if (!full || pop) m_q.push_back({rvfi_pc_rdata, rvfi_insn});
         else m_ovf = 1;
      end
      if (acc) begin
         case (cmd_op)
            2'd0: nst = 1;
            2'd1: begin nst = 0; m_why = 0; end
            2'd2: begin nst = 2; m_rem = cmd_arg == 0 ? 1 : longint'(cmd_arg); m_idle = 0; end
            default: begin nst = 3; m_rstc = 0; m_ret = 0; m_ovf = 0; m_q.delete(); end
         endcase
      end else if (m_st == 3) begin
         m_rstc++;
         if (m_rstc == RC) begin nst = 0; m_why = 0; end
      end else begin
         done = r && m_st == 2 && m_rem == 1;
         tout = m_st == 2 && !r && m_idle + 1 == TMO;
         if (m_st == 2) begin
            if (r) begin m_rem--; m_idle = 0; end
            else m_idle++;
         end
         if (r && rvfi_trap) begin nst = 0; m_why = 2; end
         else if (r && bkpt_en && rvfi_pc_rdata == bkpt_addr) begin nst = 0; m_why = 1; end
         else if (done) begin nst = 0; m_why = 0; end
         else if (tout) begin nst = 0; m_why = 3; end
      end
      m_st = nst;
   endfunction
   task automatic compare();
      chk("state", state, m_st);
      chk("halt_reason", halt_reason, m_why);
      chk("retired", retired, m_ret);
      chk("cmd_ready", cmd_ready, m_st != 3);
      chk("core_clk_en", core_clk_en, m_st == 1 || m_st == 2);
      chk("reset_core", reset_core, m_st == 3);
      chk("trace_count", trace_count, TRACE ? m_q.size() : 0);
      chk("trace_empty", trace_empty, TRACE ? m_q.size() == 0 : 1);
      chk("trace_data", trace_data, (TRACE && m_q.size() != 0) ? m_q[0] : '0);
      chk("trace_overflow", trace_overflow, TRACE ? m_ovf : 1'b0);
   endtask
   task automatic tick();
      mstep();
      @(posedge clk);
      #1;
      compare();
   endtask
   task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      tick();
      cmd_valid = 1'b0;
   endtask
   task automatic wait_halt(input string name, input int exp_n);
      int n = 0;
      while (state != 2'd0 && n < 3000) begin tick(); n++; end
      chk(name, n, exp_n);
   endtask
   typedef struct {
      bit cv; bit [1:0] op; bit [31:0] arg;
      bit rv; bit trap; bit [31:0] pc; bit be; bit [31:0] ba;
      int st; int why; longint ret;
   } vec_t;
   vec_t vt[16];
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      compare();
      reset = 1'b1;
      n = 0;
      while (reset_core && n < 50) begin tick(); n++; end
      chk("reset_core_len", n, RC);
      chk("ready_after_reset", cmd_ready, 1'b1);
      vt[0]  = '{1, 2, 3, 0, 0, 0, 0, 0, 2, 0, 0};
      vt[1]  = '{0, 0, 0, 1, 0, 'h10, 0, 0, 2, 0, 1};
      vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1};
      vt[3]  = '{0, 0, 0, 1, 0, 'h14, 0, 0, 2, 0, 2};
      vt[4]  = '{0, 0, 0, 1, 0, 'h18, 0, 0, 0, 0, 3};
      vt[5]  = '{0, 0, 0, 1, 0, 'h1c, 0, 0, 0, 0, 3};
      vt[6]  = '{1, 0, 0, 0, 0, 0, 1, 'h100, 1, 0, 3};
      vt[7]  = '{0, 0, 0, 1, 0, 'hF8, 1, 'h100, 1, 0, 4};
      vt[8]  = '{0, 0, 0, 1, 0, 'hFC, 1, 'h100, 1, 0, 5};
      vt[9]  = '{0, 0, 0, 1, 0, 'h100, 1, 'h100, 0, 1, 6};
      vt[10] = '{1, 2, 0, 0, 0, 0, 0, 0, 2, 1, 6};
      vt[11] = '{0, 0, 0, 1, 1, 'h20, 1, 'h20, 0, 2, 7};
      vt[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 7};
      vt[13] = '{0, 0, 0, 1, 0, 'h30, 0, 0, 1, 2, 8};
      vt[14] = '{1, 1, 0, 1, 0, 'h34, 0, 0, 0, 0, 9};
      vt[15] = '{1, 3, 0, 0, 0, 0, 0, 0, 3, 0, 0};
      for (int i = 0; i < 16; i++) begin
         cmd_valid = vt[i].cv; cmd_op = vt[i].op; cmd_arg = vt[i].arg;
         rvfi_valid = vt[i].rv; rvfi_trap = vt[i].trap; rvfi_pc_rdata = vt[i].pc;
         rvfi_insn = $urandom; bkpt_en = vt[i].be; bkpt_addr = vt[i].ba;
         tick();
         chk($sformatf("vec%0d_state", i), state, vt[i].st);
         chk($sformatf("vec%0d_reason", i), halt_reason, vt[i].why);
         chk($sformatf("vec%0d_retired", i), retired, vt[i].ret);
         if (i == 4) chk("step3_trace_count", trace_count, TRACE ? 3 : 0);
         if (i == 9) chk("bkpt_trace_count", trace_count, TRACE ? 6 : 0);
      end
      cmd_valid = 0; rvfi_valid = 0; rvfi_trap = 0; bkpt_en = 0;
      wait_halt("core_reset_len", RC);
      cmd(2'd2, 5);
      wait_halt("timeout_len", TMO);
      chk("timeout_reason", halt_reason, 2'd3);
      cmd(2'd2, 5);
      rvfi_valid = 1; rvfi_trap = 1; rvfi_pc_rdata = 'h40;
      tick();
      rvfi_valid = 0; rvfi_trap = 0;
      chk("trap_state", state, 2'd0);
      chk("trap_reason", halt_reason, 2'd2);
      cmd(2'd0, 0);
      rvfi_valid = 1;
      for (int i = 0; i < 3; i++) begin rvfi_pc_rdata = 'h300 + 4 * i; rvfi_insn = $urandom; tick(); end
      rvfi_valid = 0;
      #3 reset = 1'b0;
      #1;
      chk("async_state", state, 2'd3);
      chk("async_ready", cmd_ready, 1'b0);
      chk("async_clk_en", core_clk_en, 1'b0);
      chk("async_reset_core", reset_core, 1'b1);
      chk("async_retired", retired, 64'd0);
      chk("async_count", trace_count, 0);
      m_reset();
      @(posedge clk);
      #1;
      compare();
      reset = 1'b1;
      wait_halt("post_async_len", RC);
      cmd(2'd0, 0);
      rvfi_valid = 1;
      for (int i = 0; i < 17; i++) begin rvfi_pc_rdata = 'h200 + 4 * i; rvfi_insn = $urandom; tick(); end
      chk("full_count", trace_count, TRACE ? 16 : 0);
      chk("full_overflow", trace_overflow, TRACE);
      trace_rd_en = 1; rvfi_pc_rdata = 'h400;
      tick();
      chk("full_pushpop_count", trace_count, TRACE ? 16 : 0);
      trace_rd_en = 0; rvfi_valid = 0;
      cmd(2'd3, 0);
      chk("flush_count", trace_count, 0);
      chk("flush_overflow", trace_overflow, 1'b0);
      chk("flush_retired", retired, 64'd0);
      trace_rd_en = 1;
      tick();
      trace_rd_en = 0;
      wait_halt("flush_rst_len", RC - 1);
      for (int i = 0; i < 3000; i++) begin
         cmd_valid = $urandom_range(0, 9) == 0;
         cmd_op = 2'($urandom_range(0, 3));
         cmd_arg = $urandom_range(0, 4);
         rvfi_valid = $urandom_range(0, 1) == 1;
         rvfi_trap = $urandom_range(0, 15) == 0;
         rvfi_pc_rdata = 'h100 + 4 * $urandom_range(0, 7);
         rvfi_insn = $urandom;
         bkpt_en = $urandom_range(0, 1) == 1;
         bkpt_addr = 'h100 + 4 * $urandom_range(0, 7);
         trace_rd_en = $urandom_range(0, 3) == 0;
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
